// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the matrix keypad front end:
//               key-index type, NONE sentinel, ASCII mapping and repeat timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

   // Key index wide enough for an 8x8 matrix (0..63) plus the sentinel
   localparam int KEY_W = 7;
   typedef logic [KEY_W-1:0] key_idx_t;

   // No key / rejected scan; never a legal row*COLS+col value
   localparam key_idx_t KEY_NONE = 7'h7F;

   // Auto-repeat timing, counted in full scans
   localparam int REPEAT_DELAY_SCANS = 32;
   localparam int REPEAT_RATE_SCANS  = 8;

   // Standard 4x4 telephone/ATM layout "123A456B789C*0#D"; larger matrices
   // get codes above 0x80 so they never collide with printable characters
   function automatic logic [7:0] key_to_ascii(input key_idx_t idx);
      logic [7:0] code;
      case (idx)
         7'd0:    code = 8'h31;
         7'd1:    code = 8'h32;
         7'd2:    code = 8'h33;
         7'd3:    code = 8'h41;
         7'd4:    code = 8'h34;
         7'd5:    code = 8'h35;
         7'd6:    code = 8'h36;
         7'd7:    code = 8'h42;
         7'd8:    code = 8'h37;
         7'd9:    code = 8'h38;
         7'd10:   code = 8'h39;
         7'd11:   code = 8'h43;
         7'd12:   code = 8'h2A;
         7'd13:   code = 8'h30;
         7'd14:   code = 8'h23;
         7'd15:   code = 8'h44;
         default: code = 8'h80 + {1'b0, idx};
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_fifo.sv
// ============================================================================
// Module      : keypad_fifo
// Description : Small synchronous FIFO for key codes. Head is presented
//               combinationally from registered storage; simultaneous push
//               and pop on a full FIFO are both accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]              count_q, count_d;
   logic                        push_ok;
   logic                        pop_ok;

   assign full  = (count_q == COUNT_FULL);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // Accept pops only with data; a push into a full FIFO succeeds only when
   // the head leaves in the same cycle. Pointers wrap because DEPTH is 2^n.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : Matrix keypad front end. Drives one row low at a time,
//               synchronises and snapshots the columns, rejects ghost /
//               multi-key scans, debounces over whole scans, converts the
//               key index to ASCII and queues press events in a FIFO on a
//               valid/ready stream.
//               Optional: define KEYPAD_AUTOREPEAT_EN to re-queue a held key
//               after REPEAT_DELAY_SCANS and then every REPEAT_RATE_SCANS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [ROWS-1:0]              row_drive,
   input  logic [COLS-1:0]              col_sense,
   output logic [7:0]                   key_ascii,
   output logic                         key_valid,
   input  logic                         key_ready,
   output logic                         key_held,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

   // Column synchroniser
   logic [COLS-1:0]            col_meta_q, col_meta_d;
   logic [COLS-1:0]            col_sync_q, col_sync_d;

   // Scan timing and per-row snapshot (1 = key asserted)
   logic [DIV_W-1:0]           div_q, div_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic [ROWS-1:0][COLS-1:0]  snap_q, snap_d;
   logic                       sample;
   logic                       scan_done;

   // Scan result and debounce
   key_idx_t                   cand;
   logic [1:0]                 hits;
   key_idx_t                   prev_cand_q, prev_cand_d;
   logic [CNT_W-1:0]           stable_q, stable_d;
   key_idx_t                   deb_q, deb_d;
   logic                       press_evt;
   logic                       repeat_evt;

   // Event / FIFO interface
   logic                       push;
   logic [7:0]                 push_code;
   logic                       pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       overflow_q, overflow_d;

   // Two-flop synchroniser in front of the asynchronous column inputs
   always_comb begin
      col_meta_d = col_sense;
      col_sync_d = col_meta_q;
   end

   // Row divider, row walk and column snapshot; the snapshot slot for the
   // current row is refreshed on the divider's terminal count
   always_comb begin
      sample    = (div_q == DIV_LAST);
      scan_done = sample && (row_q == ROW_LAST);
      div_d     = sample ? '0 : div_q + 1'b1;
      row_d     = row_q;
      snap_d    = snap_q;
      if (sample) begin
         snap_d[row_q] = ~col_sync_q;
         row_d         = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end
   end

   // Active-low one-hot row drive decoded from the row index
   always_comb begin
      row_drive        = '1;
      row_drive[row_q] = 1'b0;
   end

   // Scan result: a single asserted contact gives its index; none or more
   // than one (ghosting / multi-press) gives NONE
   always_comb begin
      cand = KEY_NONE;
      hits = 2'd0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (snap_d[r][c]) begin
               if (hits == 2'd0) begin
                  cand = key_idx_t'(r * COLS + c);
               end
               if (hits != 2'd2) begin
                  hits = hits + 2'd1;
               end
            end
         end
      end
      if (hits != 2'd1) begin
         cand = KEY_NONE;
      end
   end

   // Whole-scan debounce; a press event is any accepted change to a real key
   always_comb begin
      prev_cand_d = prev_cand_q;
      stable_d    = stable_q;
      deb_d       = deb_q;
      press_evt   = 1'b0;
      if (scan_done) begin
         if (cand == prev_cand_q) begin
            stable_d = (stable_q == DEB_TARGET) ? stable_q : stable_q + 1'b1;
         end else begin
            stable_d = CNT_W'(1);
         end
         prev_cand_d = cand;
         if ((stable_d == DEB_TARGET) && (cand != deb_q)) begin
            deb_d     = cand;
            press_evt = (cand != KEY_NONE);
         end
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [5:0] rep_cnt_q, rep_cnt_d;
   logic       rep_phase_q, rep_phase_d;

   // Held-key repeat: first gap is the long delay, later gaps the short rate
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      repeat_evt  = 1'b0;
      if (scan_done) begin
         if (deb_d != deb_q) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
         end else if (deb_q != KEY_NONE) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
            if (rep_cnt_d == (rep_phase_q ? 6'(REPEAT_RATE_SCANS)
                                          : 6'(REPEAT_DELAY_SCANS))) begin
               repeat_evt  = 1'b1;
               rep_cnt_d   = '0;
               rep_phase_d = 1'b1;
            end
         end
      end
   end

   // Repeat counter state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end
`else
   assign repeat_evt = 1'b0;
`endif

   // Event to FIFO; a push refused by a full FIFO flags a one-cycle overflow
   always_comb begin
      push       = press_evt || repeat_evt;
      push_code  = press_evt ? key_to_ascii(cand) : key_to_ascii(deb_q);
      pop        = key_valid && key_ready;
      overflow_d = push && fifo_full && !pop;
   end

   // Scanner, debounce and overflow state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q  <= '1;
         col_sync_q  <= '1;
         div_q       <= '0;
         row_q       <= '0;
         snap_q      <= '0;
         prev_cand_q <= KEY_NONE;
         stable_q    <= '0;
         deb_q       <= KEY_NONE;
         overflow_q  <= 1'b0;
      end else begin
         col_meta_q  <= col_meta_d;
         col_sync_q  <= col_sync_d;
         div_q       <= div_d;
         row_q       <= row_d;
         snap_q      <= snap_d;
         prev_cand_q <= prev_cand_d;
         stable_q    <= stable_d;
         deb_q       <= deb_d;
         overflow_q  <= overflow_d;
      end
   end

   keypad_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_code),
      .pop   (pop),
      .rdata (key_ascii),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign key_valid = !fifo_empty;
   assign key_held  = (deb_q != KEY_NONE);
   assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner with a
//               behavioural 4x4 key matrix on the row/column lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       row_drive;
   logic [3:0]       col_sense;
   logic [7:0]       key_ascii;
   logic             key_valid;
   logic             key_ready;
   logic             key_held;
   logic             overflow;
   logic [2:0]       fifo_count;

   logic [3:0][3:0]  pressed;      // pressed[row][col]
   logic [7:0]       rx_q[$];      // codes accepted by the consumer
   int               n_valid = 0;
   int               n_ovf   = 0;
   int               n_cmp   = 0;
   int               n_err   = 0;

   keypad_scanner #(
      .ROWS           (4),
      .COLS           (4),
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row_drive  (row_drive),
      .col_sense  (col_sense),
      .key_ascii  (key_ascii),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_held   (key_held),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // Passive matrix: a closed key pulls its column low while its row is driven
   always_comb begin
      col_sense = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && !row_drive[r]) col_sense[c] = 1'b0;
   end

   // Consumer side monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid) n_valid <= n_valid + 1;
         if (key_valid && key_ready) rx_q.push_back(key_ascii);
         if (overflow) n_ovf <= n_ovf + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Return just after the edge that starts a new full scan
   task automatic wait_wrap();
      int n = 0;
      while (row_drive !== 4'b0111 && n < 100) begin tick(); n++; end
      while (row_drive !== 4'b1110 && n < 100) begin tick(); n++; end
      if (n >= 100) check("scan_timeout", n, 0);
   endtask

   task automatic wait_scans(input int n);
      repeat (n) wait_wrap();
   endtask

   task automatic press_release(input int r, input int c);
      pressed[r][c] = 1'b1;
      wait_scans(4);
      pressed[r][c] = 1'b0;
      wait_scans(4);
   endtask

   task automatic drain();
      int n = 0;
      key_ready = 1'b1;
      while (key_valid && n < 20) begin tick(); n++; end
      if (n >= 20) check("drain_timeout", n, 0);
      key_ready = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int v0;
      int o0;
      int n;

      rst       = 1'b1;
      key_ready = 1'b0;
      pressed   = '0;
      tick(); tick();
      check("rst_row_drive", row_drive, 4'b1110);
      check("rst_valid", key_valid, 0);
      check("rst_held", key_held, 0);
      check("rst_overflow", overflow, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ascii", key_ascii, 8'h00);
      rst = 1'b0;
      wait_scans(3);

      // Clean press of "6": event exactly at the end of the 3rd scan
      key_ready = 1'b1;
      base = rx_q.size();
      v0   = n_valid;
      pressed[1][2] = 1'b1;
      wait_wrap(); check("t1_scan1_valid", key_valid, 0);
      wait_wrap(); check("t1_scan2_valid", key_valid, 0);
      wait_wrap();
      check("t1_scan3_valid", key_valid, 1);
      check("t1_scan3_ascii", key_ascii, 8'h36);
      check("t1_scan3_held", key_held, 1);
      wait_scans(3);
      check("t1_events", rx_q.size() - base, 1);
      check("t1_code", rx_q[base], 8'h36);
      check("t1_valid_cycles", n_valid - v0, 1);
      check("t1_held_still", key_held, 1);
      pressed[1][2] = 1'b0;
      wait_scans(4);
      check("t1_released", key_held, 0);
      check("t1_no_release_event", rx_q.size() - base, 1);

      // Bounce for two scans then hold: one event; release and re-press: one more
      base = rx_q.size();
      pressed[1][2] = 1'b1; wait_wrap();
      pressed[1][2] = 1'b0; wait_wrap();
      check("t2_no_event_bouncing", rx_q.size() - base, 0);
      pressed[1][2] = 1'b1; wait_scans(6);
      check("t2_one_event", rx_q.size() - base, 1);
      check("t2_code", rx_q[base], 8'h36);
      pressed[1][2] = 1'b0; wait_scans(5);
      check("t2_released", key_held, 0);
      pressed[1][2] = 1'b1; wait_scans(5);
      check("t2_second_event", rx_q.size() - base, 2);
      check("t2_second_code", rx_q[base+1], 8'h36);
      pressed[1][2] = 1'b0; wait_scans(5);

      // Two keys on different rows: ghost rejected until one is released
      base = rx_q.size();
      pressed[0][0] = 1'b1;
      pressed[2][3] = 1'b1;
      wait_scans(5);
      check("t3_no_event", rx_q.size() - base, 0);
      check("t3_held", key_held, 0);
      pressed[2][3] = 1'b0;
      wait_scans(5);
      check("t3_one_event", rx_q.size() - base, 1);
      check("t3_code", rx_q[base], 8'h31);
      pressed[0][0] = 1'b0;
      wait_scans(5);

      // Five presses with no consumer: FIFO fills, fifth is dropped
      key_ready = 1'b0;
      o0 = n_ovf;
      press_release(0, 0);
      press_release(0, 1);
      press_release(0, 2);
      press_release(0, 3);
      check("t4_count_full", fifo_count, 4);
      check("t4_no_ovf_yet", n_ovf - o0, 0);
      press_release(1, 0);
      check("t4_count_after_drop", fifo_count, 4);
      check("t4_ovf_once", n_ovf - o0, 1);
      base = rx_q.size();
      drain();
      check("t4_drained", rx_q.size() - base, 4);
      check("t4_code0", rx_q[base],   8'h31);
      check("t4_code1", rx_q[base+1], 8'h32);
      check("t4_code2", rx_q[base+2], 8'h33);
      check("t4_code3", rx_q[base+3], 8'h41);
      check("t4_empty", fifo_count, 0);

      // Full FIFO: push of "5" lands in the same cycle as a pop
      press_release(0, 0);
      press_release(0, 1);
      press_release(0, 2);
      press_release(0, 3);
      check("t5_full", fifo_count, 4);
      o0   = n_ovf;
      base = rx_q.size();
      wait_wrap();
      pressed[1][1] = 1'b1;
      wait_wrap();
      wait_wrap();
      n = 0;
      while (row_drive !== 4'b0111 && n < 40) begin tick(); n++; end
      if (n >= 40) check("t5_row3_timeout", n, 0);
      tick(); tick(); tick();
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      check("t5_count_same", fifo_count, 4);
      check("t5_one_pop", rx_q.size() - base, 1);
      check("t5_popped_head", rx_q[base], 8'h31);
      pressed[1][1] = 1'b0;
      wait_scans(4);
      check("t5_no_ovf", n_ovf - o0, 0);
      drain();
      check("t5_drained", rx_q.size() - base, 5);
      check("t5_code1", rx_q[base+1], 8'h32);
      check("t5_code2", rx_q[base+2], 8'h33);
      check("t5_code3", rx_q[base+3], 8'h41);
      check("t5_code4", rx_q[base+4], 8'h35);

      // Reset mid-scan with two codes queued
      press_release(2, 0);
      press_release(2, 1);
      check("t6_queued", fifo_count, 2);
      n = 0;
      while (row_drive !== 4'b1011 && n < 40) begin tick(); n++; end
      if (n >= 40) check("t6_row2_timeout", n, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_valid", key_valid, 0);
      check("t6_count", fifo_count, 0);
      check("t6_row_drive", row_drive, 4'b1110);
      tick();
      rst = 1'b0;
      n = 0;
      while (row_drive !== 4'b1101 && n < 10) begin tick(); n++; end
      check("t6_restart", row_drive, 4'b1101);
      wait_scans(2);
      check("t6_still_empty", key_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
